p01_tt_um_chip_rom_reader: RTL and testbench
============================================

// Module: p01_tt_um_chip_rom_reader
// PURPOSE
//   Reader/scanner for an external 256x8 chip ROM. Drives byte addresses on uo_out, samples the
//   ROM's data from ui_in after a settle window, and accumulates an 8-bit sum over the scan.
//   Reports busy/done/pass on uio_out and exposes the final sum on uo_out once the scan is done.
//   Sits on the tile as a tt_um project; it is the opposite end of the ROM address->data interface.
// PARAMETERS
//   SETTLE_CYCLES  2      extra cycles each address is held before ui_in is sampled (0..15)
//   LAST_ADDR      8'hFF  final address of the scan; the scan covers 0..LAST_ADDR inclusive
//   EXPECTED_SUM   8'h00  golden mod-256 sum; pass = (sum == EXPECTED_SUM) at done
// PORTS
//   clk      in   1  single clock; all state on rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   ena      in   1  1 = run; 0 = every register holds its value
//   ui_in    in   8  ROM data byte for the address currently on uo_out
//   uo_out   out  8  ROM address while scanning; final sum in DONE; 0 in IDLE
//   uio_in   in   8  [0] start (rising edge), [7:1] ignored
//   uio_out  out  8  [2] busy, [3] done, [4] pass, [5] nonzero_seen, [1:0],[7:6] = 0
//   uio_oe   out  8  constant 8'hFC ([1:0] inputs, [7:2] outputs)
// BEHAVIOUR
//   - Reset: state=IDLE, addr=0, cnt=0, sum=0, nonzero_seen=0, start_prev=1; uo_out=0,
//     uio_out=0. start_prev=1 so a start held high through reset release does not trigger.
//   - Start edge: start_prev registers uio_in[0] every enabled cycle; edge = uio_in[0] & ~start_prev.
//   - FSM states IDLE, SCAN, DONE:
//     IDLE: on edge -> SCAN with addr=0, cnt=0, sum=0, nonzero_seen=0.
//     SCAN: busy=1; uo_out=addr. If cnt<SETTLE_CYCLES: cnt++. If cnt==SETTLE_CYCLES: sample
//       ui_in this edge: sum<=sum+ui_in (mod 256), nonzero_seen|=(ui_in!=0); if addr==LAST_ADDR
//       -> DONE, else addr++, cnt=0. Each address is held SETTLE_CYCLES+1 cycles.
//       Start edges in SCAN are ignored (no restart, no effect).
//     DONE: done=1, busy=0; uo_out=sum; pass=(sum==EXPECTED_SUM). Holds until next start edge,
//       which clears sum/nonzero_seen/addr/cnt and enters SCAN (same as from IDLE).
//   - Latency: first address appears on uo_out the cycle after the start edge; done asserts
//     (LAST_ADDR+1)*(SETTLE_CYCLES+1) cycles after entering SCAN (default 768).
//   - pass and nonzero_seen are forced 0 outside DONE (nonzero_seen internal value kept).
//   - ena=0: all registers (incl. start_prev, cnt, addr) freeze; outputs keep last values;
//     an edge occurring while ena=0 is not seen unless uio_in[0] still differs when ena returns.
//   - rst_n low at any time, including mid-scan: immediately returns to reset values; no
//     partial result survives.
//   - LAST_ADDR=0: one-byte scan; addr never wraps (no 8'hFF->0 increment ever occurs).
//   - All outputs registered or decoded from registers only; no ui_in->output combinational path.
// TESTING
//   1. ROM model all 8'h00, defaults: start pulse -> done=1 at cycle 768, pass=1, uo_out=8'h00,
//      nonzero_seen=0, busy=0.
//   2. ROM model rom[i]=i, EXPECTED_SUM=8'h80: scan -> uo_out=8'h80, pass=1, nonzero_seen=1;
//      same ROM with EXPECTED_SUM=8'h00 -> pass=0.
//   3. Address timing: uo_out=0 for cycles 1-3 after start edge, 1 for 4-6, FF for 766-768;
//      ROM model with 2-cycle data latency still passes, 3-cycle latency fails the sum.
//   4. Start pulse at addr 8'h40 mid-scan -> ignored, done still at cycle 768; second start in
//      DONE -> busy=1, done=0, uo_out=0 next cycle, sum recomputed to same value.
//   5. rst_n low at addr 8'h40 with uio_in[0] held high across release -> uio_out=0, uo_out=0,
//      stays IDLE until uio_in[0] goes low then high.
//   6. ena=0 for 10 cycles mid-scan -> done at cycle 778, uo_out/addr frozen during gap,
//      final sum identical to uninterrupted run.

Source files
------------

// File: rtl/p01_tt_um_chip_rom_reader.sv
// Scans an external 256x8 ROM address by address and sums its bytes.
// Shows the address while scanning and the mod-256 sum once done.
module p01_tt_um_chip_rom_reader #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  LAST_ADDR     = 8'hFF,
  parameter logic [7:0]  EXPECTED_SUM  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] addr;
  logic [3:0] cnt;
  logic [7:0] sum;
  logic       nonzero_seen;
  logic       start_prev;
  logic       start_edge;
  logic       sample;
  logic       last;
  logic       busy;
  logic       done;
  logic       unused_uio;

  assign start_edge = uio_in[0] & ~start_prev;
  assign sample     = (state == SCAN) && (cnt == SETTLE);
  assign last       = (addr == LAST_ADDR);
  assign unused_uio = ^uio_in[7:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_edge) state_nxt = SCAN;
      SCAN:    if (sample && last) state_nxt = DONE;
      DONE:    if (start_edge) state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  // Start edges are only honoured outside SCAN; a scan cannot restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= 8'h00;
      cnt          <= 4'h0;
      sum          <= 8'h00;
      nonzero_seen <= 1'b0;
      start_prev   <= 1'b1;
    end else if (ena) begin
      start_prev <= uio_in[0];
      if (state != SCAN && start_edge) begin
        addr         <= 8'h00;
        cnt          <= 4'h0;
        sum          <= 8'h00;
        nonzero_seen <= 1'b0;
      end else if (state == SCAN) begin
        if (sample) begin
          sum          <= sum + ui_in;
          nonzero_seen <= nonzero_seen | (ui_in != 8'h00);
          if (!last) begin
            addr <= addr + 8'h01;
            cnt  <= 4'h0;
          end
        end else begin
          cnt <= cnt + 4'h1;
        end
      end
    end
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    uo_out = 8'h00;
    unique case (state)
      SCAN: begin
        busy   = 1'b1;
        uo_out = addr;
      end
      DONE: begin
        done   = 1'b1;
        uo_out = sum;
      end
      default: ;
    endcase
  end

  assign uio_out = {2'b00,
                    done & nonzero_seen,
                    done & (sum == EXPECTED_SUM),
                    done,
                    busy,
                    2'b00};
  assign uio_oe  = 8'hFC;

endmodule

// File: tb/tb_p01_tt_um_chip_rom_reader.sv
// Bench for the ROM reader: reference model plus directed scans.
// Drives a ROM model with selectable data latency.
module tb_p01_tt_um_chip_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_80, uio_80, oe_80;
  logic [7:0] ui_one, uo_one, uio_one, oe_one;

  logic [7:0] rom [256];
  logic [7:0] hist [1:3] = '{8'h00, 8'h00, 8'h00};
  int         lat;
  int         edges;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  p01_tt_um_chip_rom_reader dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe)
  );

  p01_tt_um_chip_rom_reader #(.EXPECTED_SUM(8'h80)) dut80 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_80), .uio_in(uio_in), .uio_out(uio_80),
    .uio_oe(oe_80)
  );

  p01_tt_um_chip_rom_reader #(
    .SETTLE_CYCLES(0), .LAST_ADDR(8'h00), .EXPECTED_SUM(8'h05)
  ) dut_one (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_one),
    .uo_out(uo_one), .uio_in(uio_in), .uio_out(uio_one),
    .uio_oe(oe_one)
  );

  // ROM model: data for the address shown lat cycles earlier.
  always @(posedge clk) begin
    hist[1] <= uo_out;
    hist[2] <= hist[1];
    hist[3] <= hist[2];
  end

  always_comb begin
    case (lat)
      1:       ui_in = rom[hist[1]];
      2:       ui_in = rom[hist[2]];
      3:       ui_in = rom[hist[3]];
      default: ui_in = rom[uo_out];
    endcase
    ui_one = (uo_one == 8'h00) ? 8'h05 : 8'hEE;
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %02h expected %02h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: scan = one linear tick count per scan,
  // address = ticks / 3, a byte is taken on every third tick.
  int         m_mode;
  int         m_e;
  logic [7:0] m_sum;
  logic       m_nz;
  logic       m_prev;
  logic       m_edge;
  logic [7:0] e_uo, e_uio, e_uio80;
  logic       m_done, m_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_e = 0; m_sum = 8'h00;
      m_nz = 1'b0; m_prev = 1'b1;
    end else if (ena) begin
      m_edge = uio_in[0] & ~m_prev;
      m_prev = uio_in[0];
      if (m_mode == 1) begin
        if (m_e % 3 == 2) begin
          m_sum = m_sum + ui_in;
          m_nz  = m_nz | (ui_in != 8'h00);
        end
        m_e++;
        if (m_e == 768) m_mode = 2;
      end else if (m_edge) begin
        m_mode = 1; m_e = 0; m_sum = 8'h00; m_nz = 1'b0;
      end
    end
    #1;
    m_busy  = (m_mode == 1);
    m_done  = (m_mode == 2);
    e_uo    = m_busy ? 8'(m_e / 3) : (m_done ? m_sum : 8'h00);
    e_uio   = {2'b00, m_done & m_nz, m_done & (m_sum == 8'h00),
               m_done, m_busy, 2'b00};
    e_uio80 = {2'b00, m_done & m_nz, m_done & (m_sum == 8'h80),
               m_done, m_busy, 2'b00};
    chk("model uo_out", uo_out, e_uo);
    chk("model uio_out", uio_out, e_uio);
    chk("model uio_out80", uio_80, e_uio80);
    chk("model uio_oe", uio_oe, 8'hFC);
  end

  task automatic adv(input int n);
    if (edges < n) begin
      while (edges < n) begin
        @(posedge clk);
        edges++;
      end
      #1;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    uio_in[0] = 1'b1;
    @(posedge clk);
    #1;
    edges = 0;
    @(negedge clk);
    uio_in[0] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    lat = 0; edges = 0;
    rst_n = 1'b0; ena = 1'b1; uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'hFC);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // zero ROM, default golden sum
    do_start();
    chk("one addr0", uo_one, 8'h00);
    chk("one busy", uio_one, 8'h04);
    adv(1);
    chk("one done", uio_one, 8'h38);
    chk("one sum", uo_one, 8'h05);
    adv(5);
    chk("one hold", uo_one, 8'h05);
    adv(767);
    chk("t1 last addr", uo_out, 8'hFF);
    chk("t1 busy", uio_out, 8'h04);
    adv(768);
    chk("t1 sum", uo_out, 8'h00);
    chk("t1 done pass", uio_out, 8'h18);

    // rom[i] = i sums to 8'h80
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    do_start();
    adv(768);
    chk("t2 sum", uo_out, 8'h80);
    chk("t2 no pass", uio_out, 8'h28);
    chk("t2 pass80", uio_80, 8'h38);

    // address timing with a 2-cycle ROM
    lat = 2;
    do_start();
    chk("t3 a n0", uo_out, 8'h00);
    adv(2);
    chk("t3 a n2", uo_out, 8'h00);
    adv(3);
    chk("t3 a n3", uo_out, 8'h01);
    adv(5);
    chk("t3 a n5", uo_out, 8'h01);
    adv(765);
    chk("t3 a n765", uo_out, 8'hFF);
    adv(767);
    chk("t3 a n767", uo_out, 8'hFF);
    adv(768);
    chk("t3 lat2 sum", uo_out, 8'h80);
    chk("t3 lat2 pass", uio_80, 8'h38);

    // 3-cycle ROM: byte k-1 read for address k; first read sees
    // the old sum 8'h80 still on the bus -> 8'h80 + 8'h81 = 8'h01
    lat = 3;
    do_start();
    adv(768);
    chk("t3 lat3 sum", uo_out, 8'h01);
    chk("t3 lat3 fail", uio_80, 8'h28);
    lat = 0;

    // start pulse mid-scan is ignored
    do_start();
    adv(192);
    chk("t4 addr40", uo_out, 8'h40);
    @(negedge clk);
    uio_in[0] = 1'b1;
    adv(193);
    @(negedge clk);
    uio_in[0] = 1'b0;
    adv(767);
    chk("t4 not done", uio_out, 8'h04);
    adv(768);
    chk("t4 done", uio_out, 8'h28);
    chk("t4 sum", uo_out, 8'h80);
    do_start();
    chk("t4 restart busy", uio_out, 8'h04);
    chk("t4 restart addr", uo_out, 8'h00);
    adv(768);
    chk("t4 resum", uo_out, 8'h80);

    // reset mid-scan with start held high
    do_start();
    adv(192);
    @(negedge clk);
    rst_n = 1'b0;
    uio_in[0] = 1'b1;
    #1;
    chk("t5 rst uo_out", uo_out, 8'h00);
    chk("t5 rst uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5 idle uo_out", uo_out, 8'h00);
    chk("t5 idle uio_out", uio_out, 8'h00);
    @(negedge clk);
    uio_in[0] = 1'b0;
    do_start();
    chk("t5 scan", uio_out, 8'h04);
    adv(768);
    chk("t5 sum", uo_out, 8'h80);

    // 10-cycle enable gap
    do_start();
    adv(100);
    @(negedge clk);
    ena = 1'b0;
    adv(105);
    chk("t6 frozen a", uo_out, 8'h21);
    adv(110);
    chk("t6 frozen b", uo_out, 8'h21);
    chk("t6 busy", uio_out, 8'h04);
    @(negedge clk);
    ena = 1'b1;
    adv(777);
    chk("t6 not done", uio_out, 8'h04);
    adv(778);
    chk("t6 done", uio_out, 8'h28);
    chk("t6 sum", uo_out, 8'h80);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
